char_text_server: RTL and testbench
===================================

CHAR_TEXT_SERVER -- requirements
Module: char_text_server

Interface
REQ-001 Parameter CLEAR_CODE, default 7'h20; character code written by a clear.
REQ-002 Parameter CLEAR_ON_RESET, default 1; 1 = start a clear automatically when reset releases.
REQ-003 clk40MHz  input  1  sole clock; every flop uses its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 char_xy  input  8  read address; [3:0] column, [7:4] row of the 16x16 text grid.
REQ-006 char_line  input  4  glyph line 0..15 within the character cell.
REQ-007 char_pixel  output  8  glyph row bits; bit 7 is the leftmost pixel.
REQ-008 wr_valid  input  1  write request.
REQ-009 wr_ready  output  1  write port can accept a request.
REQ-010 wr_addr  input  8  text-grid write address, same layout as char_xy.
REQ-011 wr_code  input  7  ASCII code to store.
REQ-012 clr_req  input  1  single-cycle request to clear the whole grid.
REQ-013 busy  output  1  clear sequence in progress.

Function
REQ-014 The block SHALL hold a 256 x 7-bit text RAM: one write port and one independent read port.
REQ-015 Read pipeline, stage 1: register text_ram[char_xy] into code_q and char_line into line_q.
REQ-016 Read pipeline, stage 2: register font_rom[{code_q,line_q}] into char_pixel.
REQ-017 Read latency is exactly 2 cycles from char_xy/char_line to char_pixel, with a new result every cycle.
REQ-018 A read and a write to the same address in the same cycle SHALL return the old data (read-first); the new code is visible on the next cycle.
REQ-019 FSM state IDLE: wr_ready=1 and busy=0; a write is accepted when wr_valid and wr_ready are both high.
REQ-020 An accepted write SHALL store wr_code at wr_addr on that clock edge.
REQ-021 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with clr_cnt=0.
REQ-022 If clr_req and wr_valid are high in the same IDLE cycle, the clear wins: wr_ready is driven 0 that cycle and the write is not accepted.
REQ-023 FSM state CLEAR: write CLEAR_CODE at clr_cnt and increment clr_cnt (8 bits) every cycle; busy=1 and wr_ready=0.
REQ-024 The cycle that writes clr_cnt=255 SHALL be the last cycle of CLEAR; the FSM is in IDLE on the next cycle, so a clear lasts exactly 256 cycles.
REQ-025 clr_req during CLEAR SHALL be ignored; the counter does not restart.
REQ-026 The read pipeline SHALL keep running during CLEAR and return the current RAM contents.
REQ-027 wr_ready and busy SHALL be combinational decodes of the FSM state, except for the gating in REQ-022.

Reset
REQ-028 While rst=1: char_pixel=0, code_q=0, line_q=0, clr_cnt=0.
REQ-029 While rst=1, the FSM SHALL go to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
REQ-030 Reset SHALL NOT initialise the text RAM contents.
REQ-031 A reset asserted mid-clear SHALL abort the clear; with CLEAR_ON_RESET=1 the clear restarts from address 0.

Structure
REQ-032 Package char_pkg SHALL hold TEXT_COLS=16, TEXT_ROWS=16, CHAR_CODE_W=7, FONT_LINES=16 and the FSM state enum {IDLE, CLEAR}.
REQ-033 Sub-module font_rom SHALL implement stage 2.
REQ-034 font_rom: 11-bit address {code,line}, 128 glyphs x 16 lines, synchronous registered 8-bit output.
REQ-035 font_rom output SHALL reset to 0 under rst.
REQ-036 The text RAM and the FSM SHALL be written inline in char_text_server.

Verification
REQ-037 Reset release with CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles and wr_ready=0 throughout; afterwards reading char_xy=0x00..0xFF gives font_rom[0x20*16+line] for every address.
REQ-038 Write 0x41 at wr_addr=0x23, then char_xy=0x23 and char_line=5 -> 2 cycles later char_pixel=font_rom[0x415].
REQ-039 Same-cycle write 0x42 and read at address 0x10 holding 0x41 -> that read returns the 0x41 glyph; a read on the next cycle returns the 0x42 glyph.
REQ-040 clr_req and wr_valid high together in IDLE -> wr_ready=0, the write is lost, and after 256 cycles the target address holds 0x20.
REQ-041 rst pulsed at clear cycle 100 -> clr_cnt restarts at 0, busy stays high for a further 256 cycles, and char_pixel=0 during the reset cycle.
REQ-042 char_xy swept every cycle 0x00..0x0F with char_line=3 -> char_pixel is a continuous stream offset by exactly 2 cycles, with no bubbles.

Source files
------------

// File: rtl/char_pkg.sv
// ---------------------------------------------------------------------------
// char_pkg
// Shared constants, FSM state type and glyph generator for the character
// text server.
//   TEXT_COLS / TEXT_ROWS : text grid geometry (16 x 16 cells)
//   CHAR_CODE_W           : width of a stored character code (7-bit ASCII)
//   FONT_LINES            : glyph lines per character cell
//   clr_state_t           : clear-sequencer states {IDLE, CLEAR}
//   font_glyph()          : procedural glyph table used by font_rom
// ---------------------------------------------------------------------------
package char_pkg;

    localparam int TEXT_COLS   = 16;
    localparam int TEXT_ROWS   = 16;
    localparam int CHAR_CODE_W = 7;
    localparam int FONT_LINES  = 16;

    localparam int TEXT_ADDR_W = $clog2(TEXT_COLS * TEXT_ROWS);
    localparam int LINE_W      = $clog2(FONT_LINES);
    localparam int FONT_ADDR_W = CHAR_CODE_W + LINE_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    // The glyph table is generated rather than stored: the top and bottom
    // lines of every cell are blank spacing, the remaining lines mix the
    // character code with the line number so every (code, line) pair has a
    // distinct, easily predictable pattern.
    function automatic logic [7:0] font_glyph(input logic [CHAR_CODE_W-1:0] code,
                                              input logic [LINE_W-1:0]      line);
        logic [7:0] row;
        if (line == '0 || line == LINE_W'(FONT_LINES - 1)) begin
            row = 8'h00;
        end else begin
            row = {code, 1'b1} ^ {line, line};
        end
        return row;
    endfunction

endpackage

// File: rtl/font_rom.sv
// ---------------------------------------------------------------------------
// font_rom
// Second stage of the character read pipeline: 128 glyphs x 16 lines with a
// registered 8-bit output.
//   clk40MHz : clock, rising edge
//   rst      : synchronous active-high reset, clears the output row
//   addr     : {code[6:0], line[3:0]} glyph line address
//   pixel    : registered glyph row, bit 7 is the leftmost pixel
// ---------------------------------------------------------------------------
module font_rom
    import char_pkg::*;
(
    input  logic                   clk40MHz,
    input  logic                   rst,
    input  logic [FONT_ADDR_W-1:0] addr,
    output logic [7:0]             pixel
);

    // Registered lookup; the row is held at zero while in reset.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            pixel <= '0;
        end else begin
            pixel <= font_glyph(addr[FONT_ADDR_W-1:LINE_W], addr[LINE_W-1:0]);
        end
    end

endmodule

// File: rtl/char_text_server.sv
// ---------------------------------------------------------------------------
// char_text_server
// 16x16 character text buffer with a two-stage glyph read pipeline and a
// hardware clear sequencer.
//   clk40MHz   : clock, rising edge
//   rst        : synchronous active-high reset
//   char_xy    : read address, [3:0] column, [7:4] row
//   char_line  : glyph line within the cell
//   char_pixel : glyph row, valid 2 cycles after char_xy/char_line
//   wr_valid   : write request
//   wr_ready   : write port can accept a request
//   wr_addr    : write address, same layout as char_xy
//   wr_code    : character code to store
//   clr_req    : single-cycle request to clear the whole grid
//   busy       : clear sequence in progress
// ---------------------------------------------------------------------------
module char_text_server
    import char_pkg::*;
#(
    parameter logic [CHAR_CODE_W-1:0] CLEAR_CODE     = 7'h20,
    parameter bit                     CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk40MHz,
    input  logic                   rst,
    input  logic [TEXT_ADDR_W-1:0] char_xy,
    input  logic [LINE_W-1:0]      char_line,
    output logic [7:0]             char_pixel,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [TEXT_ADDR_W-1:0] wr_addr,
    input  logic [CHAR_CODE_W-1:0] wr_code,
    input  logic                   clr_req,
    output logic                   busy
);

    logic [CHAR_CODE_W-1:0] text_ram [TEXT_COLS*TEXT_ROWS];

    clr_state_t             state;
    clr_state_t             next_state;
    logic [TEXT_ADDR_W-1:0] clr_cnt;

    logic                   ram_we;
    logic [TEXT_ADDR_W-1:0] ram_waddr;
    logic [CHAR_CODE_W-1:0] ram_wdata;

    logic [CHAR_CODE_W-1:0] code_q;
    logic [LINE_W-1:0]      line_q;

    // State register and clear address counter. The counter only advances
    // in CLEAR and naturally wraps back to 0 after the 255 write.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 8'd1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Next state, handshake decode and RAM write-port steering. A clear
    // request in IDLE takes priority over a simultaneous write, so the
    // ready flag is withdrawn in that cycle.
    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_code;
        case (state)
            IDLE: begin
                wr_ready = ~clr_req;
                if (clr_req) begin
                    next_state = CLEAR;
                end else if (wr_valid) begin
                    ram_we = 1'b1;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = CLEAR_CODE;
                if (clr_cnt == 8'hFF) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Text RAM write port. Contents survive reset; writes are suppressed
    // while reset is asserted so an aborted clear leaves no stray entry.
    always_ff @(posedge clk40MHz) begin
        if (ram_we && !rst) begin
            text_ram[ram_waddr] <= ram_wdata;
        end
    end

    // Read stage 1. Being a separate non-blocking read of the array, a
    // same-address write in the same cycle returns the old code.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            code_q <= '0;
            line_q <= '0;
        end else begin
            code_q <= text_ram[char_xy];
            line_q <= char_line;
        end
    end

    font_rom u_font_rom (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .addr     ({code_q, line_q}),
        .pixel    (char_pixel)
    );

endmodule

// File: tb/tb_char_text_server.sv
// ---------------------------------------------------------------------------
// tb_char_text_server
// Self-checking bench for char_text_server: a cycle-level behavioural model
// (text array, remaining-clear counter, two-entry result queue) checked every
// cycle, plus directed scenarios with hand-computed glyph values.
// ---------------------------------------------------------------------------
module tb_char_text_server;

    logic       clk40MHz;
    logic       rst;
    logic [7:0] char_xy;
    logic [3:0] char_line;
    logic [7:0] char_pixel;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [6:0] wr_code;
    logic       clr_req;
    logic       busy;

    int checks;
    int errors;

    char_text_server dut (
        .clk40MHz   (clk40MHz),
        .rst        (rst),
        .char_xy    (char_xy),
        .char_line  (char_line),
        .char_pixel (char_pixel),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_code    (wr_code),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    initial clk40MHz = 1'b0;
    always #10 clk40MHz = ~clk40MHz;

    // Glyph rule: blank first/last line, otherwise (2*code+1) xor (17*line).
    function automatic logic [7:0] model_glyph(input logic [6:0] code, input logic [3:0] line);
        int c;
        int l;
        c = int'(code);
        l = int'(line);
        if (l == 0 || l == 15) return 8'h00;
        return 8'((c * 2 + 1) ^ (l * 17));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk40MHz);
        #1;
    endtask

    // Drive one cycle worth of inputs, then advance past the next edge.
    task automatic applyStimulus(input logic [7:0] xy, input logic [3:0] line,
                                 input logic wv, input logic [7:0] waddr,
                                 input logic [6:0] wcode, input logic clr);
        char_xy   = xy;
        char_line = line;
        wr_valid  = wv;
        wr_addr   = waddr;
        wr_code   = wcode;
        clr_req   = clr;
        tick();
    endtask

    // Count cycles with busy high (bounded), optionally pulsing clr_req.
    task automatic measureBusy(input int pulse_at, output int n, output int ready_seen);
        n = 0;
        ready_seen = 0;
        while (busy === 1'b1 && n < 1000) begin
            clr_req = (n == pulse_at);
            #1;
            if (wr_ready !== 1'b0) ready_seen++;
            n++;
            tick();
        end
        clr_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [6:0] m_ram [256];
    bit         m_ok  [256];
    int         clear_left;
    int         clear_addr;
    logic [7:0] s1_val;
    bit         s1_ok;
    logic [7:0] s2_val;
    bit         s2_ok;
    bit         model_live;

    initial begin
        for (int i = 0; i < 256; i++) m_ok[i] = 1'b0;
        model_live = 1'b0;
        clear_left = 0;
        clear_addr = 0;
        s1_ok = 1'b0;
        s2_ok = 1'b0;
        s1_val = '0;
        s2_val = '0;
    end

    always @(posedge clk40MHz) begin
        if (rst) begin
            model_live = 1'b1;
            clear_left = 256;
            clear_addr = 0;
            s1_val = model_glyph(7'h00, 4'h0);
            s1_ok  = 1'b1;
            s2_val = 8'h00;
            s2_ok  = 1'b1;
        end else if (model_live) begin
            s2_val = s1_val;
            s2_ok  = s1_ok;
            s1_ok  = m_ok[char_xy];
            s1_val = model_glyph(m_ram[char_xy], char_line);
            if (clear_left > 0) begin
                m_ram[clear_addr] = 7'h20;
                m_ok[clear_addr]  = 1'b1;
                clear_addr++;
                clear_left--;
            end else if (clr_req) begin
                clear_left = 256;
                clear_addr = 0;
            end else if (wr_valid) begin
                m_ram[wr_addr] = wr_code;
                m_ok[wr_addr]  = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk40MHz) begin
        if (model_live) begin
            checkOutput("model_busy", 32'(busy), 32'(clear_left > 0));
            checkOutput("model_wr_ready", 32'(wr_ready), 32'(clear_left == 0 && !clr_req));
            if (s2_ok) checkOutput("model_pixel", 32'(char_pixel), 32'(s2_val));
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int n;
        int rdy;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        char_xy = '0; char_line = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_code = '0; clr_req = 1'b0;
        #1;
        tick(); tick(); tick();
        checkOutput("reset_pixel", 32'(char_pixel), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h1);

        // Clear after reset release, with an ignored clr_req mid-way.
        rst = 1'b0;
        measureBusy(50, n, rdy);
        checkOutput("reset_clear_len", 32'(n), 32'd256);
        checkOutput("reset_clear_ready", 32'(rdy), 32'd0);
        checkOutput("idle_ready", 32'(wr_ready), 32'h1);

        // Every cell now holds 0x20; line 3 glyph is 0x72.
        for (int a = 0; a < 256; a++) begin
            applyStimulus(8'(a), 4'd3, 1'b0, 8'h00, 7'h00, 1'b0);
            if (a >= 1) checkOutput("cleared_cell", 32'(char_pixel), 32'h72);
        end
        tick(); tick();

        // Write then read back 0x41 at 0x23, line 5 -> 0xD6.
        applyStimulus(8'h00, 4'd0, 1'b1, 8'h23, 7'h41, 1'b0);
        applyStimulus(8'h23, 4'd5, 1'b0, 8'h00, 7'h00, 1'b0);
        applyStimulus(8'h00, 4'd0, 1'b0, 8'h00, 7'h00, 1'b0);
        checkOutput("write_read_0x23", 32'(char_pixel), 32'hD6);

        // Read-first collision at 0x10: old 0x41 (0xD6), then 0x42 (0xD0).
        applyStimulus(8'h00, 4'd0, 1'b1, 8'h10, 7'h41, 1'b0);
        applyStimulus(8'h10, 4'd5, 1'b1, 8'h10, 7'h42, 1'b0);
        applyStimulus(8'h10, 4'd5, 1'b0, 8'h00, 7'h00, 1'b0);
        checkOutput("collision_old", 32'(char_pixel), 32'hD6);
        applyStimulus(8'h00, 4'd0, 1'b0, 8'h00, 7'h00, 1'b0);
        checkOutput("collision_new", 32'(char_pixel), 32'hD0);

        // Streaming sweep over distinct codes 0x30+i, line 3.
        for (int i = 0; i < 16; i++) applyStimulus(8'h00, 4'd0, 1'b1, 8'(i), 7'(8'h30 + i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 4'd3, 1'b0, 8'h00, 7'h00, 1'b0);
            if (i == 1) checkOutput("sweep_addr0", 32'(char_pixel), 32'h52);
            if (i == 2) checkOutput("sweep_addr1", 32'(char_pixel), 32'h50);
        end
        tick(); tick();

        // Clear beats a simultaneous write; 0x55 keeps 0x33 until cleared.
        applyStimulus(8'h00, 4'd0, 1'b1, 8'h55, 7'h33, 1'b0);
        char_xy = 8'h55; char_line = 4'd5;
        wr_valid = 1'b1; wr_addr = 8'h55; wr_code = 7'h41; clr_req = 1'b1;
        #2;
        checkOutput("clr_beats_write_ready", 32'(wr_ready), 32'h0);
        tick();
        wr_valid = 1'b0; clr_req = 1'b0;
        tick();
        checkOutput("lost_write_old_glyph", 32'(char_pixel), 32'h32);
        measureBusy(-1, n, rdy);
        checkOutput("clr_req_clear_len", 32'(n), 32'd255);
        applyStimulus(8'h55, 4'd3, 1'b0, 8'h00, 7'h00, 1'b0);
        applyStimulus(8'h00, 4'd0, 1'b0, 8'h00, 7'h00, 1'b0);
        checkOutput("lost_write_cleared", 32'(char_pixel), 32'h72);

        // Reset mid-clear restarts the full sequence; writes ignored meanwhile.
        applyStimulus(8'h00, 4'd0, 1'b1, 8'hAA, 7'h41, 1'b0);
        applyStimulus(8'h00, 4'd0, 1'b0, 8'h00, 7'h00, 1'b1);
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        checkOutput("midclear_reset_pixel", 32'(char_pixel), 32'h0);
        checkOutput("midclear_reset_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'hAA; wr_code = 7'h41;
        measureBusy(-1, n, rdy);
        wr_valid = 1'b0;
        checkOutput("restart_clear_len", 32'(n), 32'd256);
        checkOutput("restart_clear_ready", 32'(rdy), 32'd0);
        applyStimulus(8'hAA, 4'd3, 1'b0, 8'h00, 7'h00, 1'b0);
        applyStimulus(8'h00, 4'd0, 1'b0, 8'h00, 7'h00, 1'b0);
        checkOutput("write_during_clear_ignored", 32'(char_pixel), 32'h72);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
